// File: rtl/text_dump_tx.sv
// UART (8N1) dump of the 32x4 character buffer: four rows, each terminated by CR/LF.
// Reads the buffer through a synchronous-read port; tx idles high and is driven from a register.
module text_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned COLS         = 32,
    parameter int unsigned ROWS         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] rd_row,
    output logic [4:0] rd_col,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_COL  = 5'(COLS - 1);
    localparam logic [1:0]    LAST_ROW  = 2'(ROWS - 1);
    localparam logic [3:0]    STOP_BIT  = 4'd9;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_FETCH, S_SEND, S_NEXT, S_DONE} state_t;
    typedef enum logic [1:0] {K_CHAR, K_CR, K_LF} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [1:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic [7:0]    sh_q, sh_d;
    logic [3:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADDR;
            S_ADDR:  state_d = S_FETCH;
            S_FETCH: state_d = S_SEND;
            S_SEND:  if (bit_q == STOP_BIT && baud_q == BAUD_LAST) state_d = S_NEXT;
            S_NEXT: begin
                case (kind_q)
                    K_CHAR:  state_d = (col_q != LAST_COL) ? S_ADDR : S_SEND;
                    K_CR:    state_d = S_SEND;
                    default: state_d = (row_q != LAST_ROW) ? S_ADDR : S_DONE;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every frame start (FETCH, or NEXT loading CR/LF) drives the start bit on the same edge.
    always_comb begin
        kind_d = kind_q;
        row_d  = row_q;
        col_d  = col_q;
        sh_d   = sh_q;
        bit_d  = bit_q;
        baud_d = baud_q;
        tx_d   = tx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d  = '0;
                    col_d  = '0;
                    kind_d = K_CHAR;
                end
            end
            S_FETCH: begin
                sh_d   = (rd_data < 8'h20 || rd_data >= 8'h7F) ? 8'h20 : rd_data;
                bit_d  = '0;
                baud_d = '0;
                tx_d   = 1'b0;
            end
            S_SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q != STOP_BIT) begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : sh_q[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_NEXT: begin
                case (kind_q)
                    K_CHAR: begin
                        if (col_q != LAST_COL) begin
                            col_d = col_q + 5'd1;
                        end else begin
                            kind_d = K_CR;
                            sh_d   = 8'h0D;
                            bit_d  = '0;
                            baud_d = '0;
                            tx_d   = 1'b0;
                        end
                    end
                    K_CR: begin
                        kind_d = K_LF;
                        sh_d   = 8'h0A;
                        bit_d  = '0;
                        baud_d = '0;
                        tx_d   = 1'b0;
                    end
                    default: begin
                        if (row_q != LAST_ROW) begin
                            row_d  = row_q + 2'd1;
                            col_d  = '0;
                            kind_d = K_CHAR;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind_q <= K_CHAR;
            row_q  <= '0;
            col_q  <= '0;
            sh_q   <= '0;
            bit_q  <= '0;
            baud_q <= '0;
            tx_q   <= 1'b1;
        end else begin
            kind_q <= kind_d;
            row_q  <= row_d;
            col_q  <= col_d;
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            baud_q <= baud_d;
            tx_q   <= tx_d;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE) && (state_q != S_DONE);
        done   = (state_q == S_DONE);
        rd_row = row_q;
        rd_col = col_q;
        tx     = tx_q;
    end

endmodule
